// File: rtl/io_cond_pkg.sv
// ----------------------------------------------------------------------------
// io_cond_pkg
// Shared constants and helpers for the board input conditioner.
//   KEY_RELEASED : idle level of an active-low key (synchroniser reset value)
//   SW_RESET     : level a switch channel assumes while in reset
//   clog2_f      : ceiling log2, used to size counters and pointers
// ----------------------------------------------------------------------------
package io_cond_pkg;

    localparam logic KEY_RELEASED = 1'b1;
    localparam logic SW_RESET     = 1'b0;

    // Ceiling log2; clog2_f(1) is 0, so callers size "count up to N" fields
    // with clog2_f(N + 1).
    function automatic int clog2_f(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/io_input_conditioner_debounce_channel.sv
// ----------------------------------------------------------------------------
// debounce_channel
// One input bit: 2-flop synchroniser, debounce counter, accepted level and a
// one-cycle change pulse registered together with the level.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive differing samples needed to accept a level
//   RESET_LEVEL     : level held by the synchroniser and output in reset
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   din     in   raw asynchronous input
//   level   out  debounced level
//   changed out  one-cycle pulse in the cycle level takes a new value
// ----------------------------------------------------------------------------
module debounce_channel
    import io_cond_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic changed
);

    localparam int            CW       = clog2_f(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    // Stage p0/p1: metastability synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= RESET_LEVEL;
            sync_p1 <= RESET_LEVEL;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: debounce counter and accepted level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level   <= RESET_LEVEL;
            cnt     <= '0;
            changed <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level   <= sync_p1;
                cnt     <= '0;
                changed <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_input_conditioner.sv
// ----------------------------------------------------------------------------
// io_input_conditioner
// Board input front end: debounces NUM_KEYS active-low keys and NUM_SW
// switches, produces press/change pulses and queues key-press bitmaps in a
// small show-ahead FIFO.
//
// Optional build macro IO_COND_AUTOREPEAT_EN: adds REPEAT_DELAY and
// REPEAT_PERIOD; a key held down re-issues key_press (and a FIFO push)
// REPEAT_DELAY cycles after the press, then every REPEAT_PERIOD cycles.
//
// Ports
//   clock_50M       in   system clock
//   resetn          in   asynchronous active-low reset
//   key_n           in   raw keys, 0 = pressed
//   sw              in   raw switches
//   key_down        out  debounced key level, 1 = held
//   key_press       out  one-cycle pulse per debounced press
//   sw_level        out  debounced switch level
//   sw_changed      out  one-cycle pulse per debounced toggle
//   ev_valid        out  event FIFO not empty
//   ev_data         out  head event (bitmap of keys pressed together), 0 if empty
//   ev_ready        in   pop request, honoured when ev_valid
//   ev_count        out  FIFO occupancy
//   ev_overflow     out  sticky flag: an event was dropped on a full FIFO
//   ev_overflow_clr in   clears ev_overflow (a simultaneous drop wins)
// ----------------------------------------------------------------------------
module io_input_conditioner
    import io_cond_pkg::*;
#(
    parameter int NUM_KEYS        = 3,
    parameter int NUM_SW          = 10,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_W           = clog2_f(FIFO_DEPTH + 1)
`ifdef IO_COND_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
`endif
) (
    input  logic                clock_50M,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [NUM_SW-1:0]   sw,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_SW-1:0]   sw_level,
    output logic [NUM_SW-1:0]   sw_changed,
    output logic                ev_valid,
    output logic [NUM_KEYS-1:0] ev_data,
    input  logic                ev_ready,
    output logic [CNT_W-1:0]    ev_count,
    output logic                ev_overflow,
    input  logic                ev_overflow_clr
);

    localparam int NCH = NUM_KEYS + NUM_SW;
    localparam int AW  = clog2_f(FIFO_DEPTH);

    logic [NCH-1:0]      raw_in;
    logic [NCH-1:0]      ch_level;
    logic [NCH-1:0]      ch_changed;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_chg;
    logic [NUM_KEYS-1:0] key_press_base;

    // Keys occupy the low channels, switches the high ones.
    assign raw_in = {sw, key_n};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     ((i < NUM_KEYS) ? KEY_RELEASED : SW_RESET)
        ) u_db (
            .clk     (clock_50M),
            .rst_n   (resetn),
            .din     (raw_in[i]),
            .level   (ch_level[i]),
            .changed (ch_changed[i])
        );
    end

    assign key_level  = ch_level[NUM_KEYS-1:0];
    assign key_chg    = ch_changed[NUM_KEYS-1:0];
    assign sw_level   = ch_level[NCH-1:NUM_KEYS];
    assign sw_changed = ch_changed[NCH-1:NUM_KEYS];

    // Level and pulse update on the same edge, so a change that leaves the
    // key down is a press; a change that leaves it up is a release.
    assign key_down       = ~key_level;
    assign key_press_base = key_chg & key_down;

`ifdef IO_COND_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = clog2_f(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]       rep_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] rep_fire;

    // Counter holds cycles remaining until the next repeat; it sits at the
    // delay reload while the key is up and is reloaded on the press itself.
    always_comb begin
        rep_fire = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            rep_fire[k] = key_down[k] && !key_press_base[k] && (rep_cnt[k] == '0);
        end
    end

    always_ff @(posedge clock_50M or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                rep_cnt[k] <= DELAY_LOAD;
            end
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (!key_down[k] || key_press_base[k]) begin
                    rep_cnt[k] <= DELAY_LOAD;
                end else if (rep_cnt[k] == '0) begin
                    rep_cnt[k] <= PERIOD_LOAD;
                end else begin
                    rep_cnt[k] <= rep_cnt[k] - 1'b1;
                end
            end
        end
    end

    assign key_press = key_press_base | rep_fire;
`else
    assign key_press = key_press_base;
`endif

    // Event FIFO: power-of-two depth, so pointers wrap by natural overflow.
    logic [NUM_KEYS-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                push;
    logic                pop;
    logic                full;
    logic                do_push;
    logic                drop;

    assign push     = |key_press;
    assign ev_valid = (ev_count != '0);
    assign pop      = ev_valid && ev_ready;
    assign full     = (ev_count == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot the push needs.
    assign do_push  = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign ev_data  = ev_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clock_50M) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= key_press;
        end
    end

    always_ff @(posedge clock_50M or negedge resetn) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ev_count    <= '0;
            ev_overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   ev_count <= ev_count + 1'b1;
                2'b01:   ev_count <= ev_count - 1'b1;
                default: ev_count <= ev_count;
            endcase
            if (drop) begin
                ev_overflow <= 1'b1;
            end else if (ev_overflow_clr) begin
                ev_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_io_input_conditioner.sv
module tb_io_input_conditioner;

    localparam int NK = 3;
    localparam int NS = 10;
    localparam int DB = 4;
    localparam int FD = 4;
    localparam int CW = 3;
    localparam logic [NS-1:0] SW_A = 10'b0101110110;
    localparam logic [NS-1:0] SW_B = 10'b1010001001;

    logic          clock_50M = 1'b0;
    logic          resetn = 1'b0;
    logic [NK-1:0] key_n = '1;
    logic [NS-1:0] sw = '0;
    logic          ev_ready = 1'b0;
    logic          ev_overflow_clr = 1'b0;
    logic [NK-1:0] key_down;
    logic [NK-1:0] key_press;
    logic [NS-1:0] sw_level;
    logic [NS-1:0] sw_changed;
    logic          ev_valid;
    logic [NK-1:0] ev_data;
    logic [CW-1:0] ev_count;
    logic          ev_overflow;

    always #10 clock_50M = ~clock_50M;

    io_input_conditioner #(
        .NUM_KEYS        (NK),
        .NUM_SW          (NS),
        .DEBOUNCE_CYCLES (DB),
        .FIFO_DEPTH      (FD)
    ) dut (
        .clock_50M       (clock_50M),
        .resetn          (resetn),
        .key_n           (key_n),
        .sw              (sw),
        .key_down        (key_down),
        .key_press       (key_press),
        .sw_level        (sw_level),
        .sw_changed      (sw_changed),
        .ev_valid        (ev_valid),
        .ev_data         (ev_data),
        .ev_ready        (ev_ready),
        .ev_count        (ev_count),
        .ev_overflow     (ev_overflow),
        .ev_overflow_clr (ev_overflow_clr)
    );

    int            n_vec = 0;
    int            n_bad = 0;
    logic [NK-1:0] exp_q [$];
    logic          model_ovf = 1'b0;
    int            key_cnt [NK];
    int            sw_cnt [NS];

    // Pulse counters, sampled shortly after each rising edge.
    always @(posedge clock_50M) begin
        #2;
        for (int k = 0; k < NK; k++) if (key_press[k]) key_cnt[k]++;
        for (int s = 0; s < NS; s++) if (sw_changed[s]) sw_cnt[s]++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NK; k++) key_cnt[k] = 0;
        for (int s = 0; s < NS; s++) sw_cnt[s] = 0;
    endtask

    task automatic press_key(input logic [NK-1:0] mask);
        @(negedge clock_50M);
        key_n = ~mask;
        if (exp_q.size() < FD) exp_q.push_back(mask);
        else model_ovf = 1'b1;
        repeat (20) @(negedge clock_50M);
        key_n = '1;
        repeat (12) @(negedge clock_50M);
    endtask

    task automatic pop_check(input string tag);
        logic [NK-1:0] exp;
        @(negedge clock_50M);
        if (exp_q.size() == 0) begin
            check({tag, "_valid"}, ev_valid, 0);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_valid"}, ev_valid, 1);
            check({tag, "_data"}, ev_data, exp);
            ev_ready = 1'b1;
            @(negedge clock_50M);
            ev_ready = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_kdown"}, key_down, 0);
        check({tag, "_kpress"}, key_press, 0);
        check({tag, "_swlvl"}, sw_level, 0);
        check({tag, "_swchg"}, sw_changed, 0);
        check({tag, "_valid"}, ev_valid, 0);
        check({tag, "_data"}, ev_data, 0);
        check({tag, "_count"}, ev_count, 0);
        check({tag, "_ovf"}, ev_overflow, 0);
    endtask

    task automatic check_sw_pulses(input string tag, input logic [NS-1:0] exp_mask);
        logic [NS-1:0] ones;
        logic [NS-1:0] multi;
        for (int s = 0; s < NS; s++) begin
            ones[s]  = (sw_cnt[s] == 1);
            multi[s] = (sw_cnt[s] > 1);
        end
        check({tag, "_once"}, ones, exp_mask);
        check({tag, "_multi"}, multi, 0);
    endtask

    initial begin
        logic [NK-1:0] head;
        clear_counts();

        // Reset state
        repeat (3) @(negedge clock_50M);
        check_all_zero("rst");
        resetn = 1'b1;
        repeat (2) @(negedge clock_50M);

        // Single press: pulse exactly on the 6th sampling edge
        clear_counts();
        @(negedge clock_50M);
        key_n[0] = 1'b0;
        exp_q.push_back(3'b001);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clock_50M);
            #1;
            if (i == 5) check("kp0_c5", key_press[0], 0);
            if (i == 6) check("kp0_c6", key_press[0], 1);
            if (i == 7) check("kp0_c7", key_press[0], 0);
        end
        repeat (12) @(negedge clock_50M);
        check("kp0_down", key_down[0], 1);
        check("kp0_npulse", key_cnt[0], 1);
        check("kp0_count", ev_count, 1);
        clear_counts();
        key_n[0] = 1'b1;
        repeat (12) @(negedge clock_50M);
        check("kp0_rel_pulse", key_cnt[0], 0);
        check("kp0_rel_down", key_down[0], 0);
        pop_check("kp0_pop");

        // Glitch of 3 cycles is filtered
        clear_counts();
        @(negedge clock_50M);
        key_n[1] = 1'b0;
        repeat (3) @(negedge clock_50M);
        key_n[1] = 1'b1;
        repeat (2) @(negedge clock_50M);
        check("glitch_down", key_down[1], 0);
        repeat (10) @(negedge clock_50M);
        check("glitch_pulse", key_cnt[1], 0);
        check("glitch_count", ev_count, 0);

        // Simultaneous keys share one entry
        clear_counts();
        press_key(3'b101);
        check("sim_k0", key_cnt[0], 1);
        check("sim_k1", key_cnt[1], 0);
        check("sim_k2", key_cnt[2], 1);
        check("sim_count", ev_count, 1);
        pop_check("sim_pop");

        // Overflow: five presses into depth four
        press_key(3'b001);
        press_key(3'b010);
        press_key(3'b100);
        press_key(3'b001);
        press_key(3'b010);
        check("ovf_count", ev_count, FD);
        check("ovf_flag", ev_overflow, model_ovf);

        // Full FIFO with push and pop in the same cycle
        @(negedge clock_50M);
        key_n = ~3'b100;
        repeat (6) @(posedge clock_50M);
        @(negedge clock_50M);
        check("pp_press", key_press, 3'b100);
        head = exp_q.pop_front();
        exp_q.push_back(3'b100);
        check("pp_head", ev_data, head);
        ev_ready = 1'b1;
        @(negedge clock_50M);
        ev_ready = 1'b0;
        check("pp_count", ev_count, FD);
        check("pp_ovf", ev_overflow, model_ovf);
        repeat (14) @(negedge clock_50M);
        key_n = '1;
        repeat (12) @(negedge clock_50M);

        // Clear sticky overflow
        ev_overflow_clr = 1'b1;
        @(negedge clock_50M);
        ev_overflow_clr = 1'b0;
        model_ovf = 1'b0;
        check("ovf_clr", ev_overflow, model_ovf);

        // Drain in order
        for (int i = 0; i < FD; i++) pop_check("drain");
        @(negedge clock_50M);
        check("drain_valid", ev_valid, 0);
        check("drain_data", ev_data, 0);
        check("drain_count", ev_count, 0);
        ev_ready = 1'b1;
        @(negedge clock_50M);
        ev_ready = 1'b0;
        check("empty_pop", ev_count, 0);

        // Reset mid-debounce with switches moving and key 2 held through it
        @(negedge clock_50M);
        sw = SW_A;
        key_n[2] = 1'b0;
        repeat (3) @(negedge clock_50M);
        resetn = 1'b0;
        exp_q.delete();
        model_ovf = 1'b0;
        #1;
        check_all_zero("mid_rst");
        repeat (3) @(negedge clock_50M);
        check_all_zero("mid_rst_hold");
        clear_counts();
        resetn = 1'b1;
        exp_q.push_back(3'b100);
        repeat (1500) @(negedge clock_50M);
        check("post_rst_sw", sw_level, SW_A);
        check_sw_pulses("post_rst", SW_A);
        check("held_key_press", key_cnt[2], 1);
        pop_check("held_key_pop");
        key_n[2] = 1'b1;

        // Full-width toggles
        for (int t = 0; t < 4; t++) begin
            clear_counts();
            @(negedge clock_50M);
            sw = (t % 2 == 0) ? SW_B : SW_A;
            repeat (1500) @(negedge clock_50M);
            check("tog_level", sw_level, (t % 2 == 0) ? SW_B : SW_A);
            check_sw_pulses("tog", '1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
- Parametrised input front end for the single-cycle computer's board I/O.
- Synchronises and debounces NUM_KEYS active-low push keys and NUM_SW slide switches.
- Produces clean levels, one-cycle press/change pulses, and a small press-event FIFO with a valid/ready handshake.
- Sits between the board pins and the memory-mapped I/O port logic of sc_computer_main, replacing raw key/sw wiring.

Parameters:
- NUM_KEYS, 3, number of active-low keys (1..8).
- NUM_SW, 10, number of switches (1..16).
- DEBOUNCE_CYCLES, 4, stable-sample cycles required before a level is accepted (>=1); board builds use 1000000.
- FIFO_DEPTH, 4, event FIFO entries; power of two, >=2.
- CNT_W, derived, $clog2(FIFO_DEPTH+1).

Ports:
- clock_50M  in  1  system clock; all state on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- key_n  in  NUM_KEYS  raw keys, 0 = pressed, asynchronous.
- sw  in  NUM_SW  raw switches, asynchronous.
- key_down  out  NUM_KEYS  debounced level, 1 = held.
- key_press  out  NUM_KEYS  one-cycle pulse on a debounced press.
- sw_level  out  NUM_SW  debounced switch level.
- sw_changed  out  NUM_SW  one-cycle pulse on a debounced toggle.
- ev_valid  out  1  FIFO not empty.
- ev_data  out  NUM_KEYS  head entry, a bitmap of keys pressed in one cycle.
- ev_ready  in  1  consumer pop; pop occurs when ev_valid && ev_ready.
- ev_count  out  CNT_W  occupancy.
- ev_overflow  out  1  sticky: a push was dropped.
- ev_overflow_clr  in  1  clears ev_overflow.

Behaviour:
- Reset (async assert, sync release):
  - Key synchronisers 1; switch synchronisers 0; counters 0.
  - key_down 0, key_press 0, sw_level 0, sw_changed 0.
  - FIFO empty: ev_valid 0, ev_data 0, ev_count 0. ev_overflow 0.
  - Reset mid-debounce discards the partial count.
  - A key held through reset is reported as a press once it has debounced after release.
- Per channel (keys and switches identical):
  - 2-flop synchroniser feeds a debounce counter.
  - sync == stable: counter <= 0.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
  - Otherwise counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
  - Latency from the first clock edge sampling a new level to the stable update is DEBOUNCE_CYCLES+2 clocks.
  - key_press and sw_changed are asserted in the same cycle stable changes, for exactly one cycle.
  - key_press fires on press only, never on release.
- Event FIFO:
  - Any nonzero key_press pushes one entry equal to key_press, so simultaneous presses share one entry.
  - Show-ahead: ev_data is the head entry while ev_valid; ev_data is 0 when empty.
  - Full with push and no pop: entry dropped, ev_overflow <= 1.
  - Full with push and pop in the same cycle: both happen, count unchanged, no overflow.
  - Empty with push: ev_valid rises the next cycle; a pop is ignored while ev_valid is 0.
  - Pointers wrap modulo FIFO_DEPTH.
  - ev_overflow_clr in the same cycle as a new drop: the drop wins and the flag stays 1.

Optional Feature:
- Macro IO_COND_AUTOREPEAT_EN.
- Defined:
  - Adds parameters REPEAT_DELAY (default 16) and REPEAT_PERIOD (default 8).
  - A key held continuously generates extra key_press pulses, and FIFO pushes, REPEAT_DELAY cycles after the initial press, then every REPEAT_PERIOD cycles.
  - Release or reset stops repeating and reloads the repeat counter.
- Undefined:
  - No repeat logic or parameters.
  - Exactly one key_press per debounced press.

Decomposition:
- Shared package io_cond_pkg holds:
  - Default constants KEY_RELEASED=1'b1 and SW_RESET=1'b0.
  - Function clog2_f, used for counter widths.
- Natural sub-module debounce_channel: synchroniser, counter, stable register and edge pulse for one bit.
  - Parameters DEBOUNCE_CYCLES and RESET_LEVEL.
  - Instantiated with a generate loop NUM_KEYS + NUM_SW times.
- FIFO stays inline.

Test Plan:
- key_n[0] 1->0 held 20 clocks (DEBOUNCE_CYCLES=4) -> key_press[0] single pulse at clock 6; key_down[0]=1; one FIFO entry 3'b001; release gives no pulse.
- key_n[1] low for 3 clocks then high -> no key_press, key_down stays 0, ev_count 0.
- key_n[0] and key_n[2] pressed on the same edge -> one entry 3'b101; ev_count=1.
- 5 separate presses with ev_ready=0 (depth 4) -> ev_count=4, ev_overflow=1; four pops return the entries in order; ev_valid then 0.
- Full FIFO, press and ev_ready=1 in the same cycle -> ev_count stays 4, ev_overflow unchanged.
- sw toggling 10'b0101110110 <-> 10'b1010001001 every 1500 clocks, resetn pulsed low mid-debounce -> all outputs 0 during reset; each later toggle pulses all 10 sw_changed bits once; sw_level follows.
